// File: rtl/sfifo_flagged_pkg.sv
// sfifo_pkg: depth helper and threshold legality checks shared by the flagged FIFO.
package sfifo_pkg;
  function automatic int fifo_depth(input int lg);
    return 1 << lg;
  endfunction
  function automatic bit lg_ok(input int lg);
    return lg >= 1 && lg <= 12;
  endfunction
  function automatic bit af_thresh_ok(input int lg, input int af);
    return af >= 1 && af <= fifo_depth(lg);
  endfunction
  function automatic bit ae_thresh_ok(input int lg, input int ae);
    return ae >= 0 && ae < fifo_depth(lg);
  endfunction
endpackage

// File: rtl/sfifo_flagged_if.sv
// sfifo_flagged_if: write/read handshake, level flags and error flags of the flagged FIFO.
interface sfifo_flagged_if #(parameter int BW = 8, parameter int LGFLEN = 4);
  logic              i_wr;
  logic [BW-1:0]     i_data;
  logic              o_full;
  logic              o_afull;
  logic [LGFLEN:0]   o_fill;
  logic              i_rd;
  logic [BW-1:0]     o_data;
  logic              o_empty;
  logic              o_aempty;
  logic              o_overflow;
  logic              o_underflow;
  logic              i_clr_err;
  modport master(output i_wr, i_data, i_rd, i_clr_err,
                 input o_full, o_afull, o_fill, o_data, o_empty, o_aempty, o_overflow, o_underflow);
  modport slave(input i_wr, i_data, i_rd, i_clr_err,
                output o_full, o_afull, o_fill, o_data, o_empty, o_aempty, o_overflow, o_underflow);
endinterface

// File: rtl/sfifo_flagged_mem.sv
// sfifo_mem: simple dual-port RAM, synchronous write, asynchronous read.
module sfifo_mem #(parameter int BW = 8, parameter int LGFLEN = 4) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [LGFLEN-1:0] i_waddr,
  input  logic [BW-1:0]     i_wdata,
  input  logic [LGFLEN-1:0] i_raddr,
  output logic [BW-1:0]     o_rdata
);
  logic [BW-1:0] r_mem [(1<<LGFLEN)];
  always_ff @(posedge i_clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/sfifo_flagged.sv
// sfifo_flagged: FWFT synchronous FIFO with registered fill/level flags, thresholds and sticky errors.
// Define SFIFO_RW_ON_FULL_EN to let a write at full be accepted alongside a same-cycle read.
module sfifo_flagged
  import sfifo_pkg::*;
#(
  parameter int BW        = 8,
  parameter int LGFLEN    = 4,
  parameter int AF_THRESH = (1 << LGFLEN) - 1,
  parameter int AE_THRESH = 1
) (
  input logic           i_clk,
  input logic           i_reset,
  sfifo_flagged_if.slave bus
);
  localparam int DEPTH = fifo_depth(LGFLEN);
  if (!lg_ok(LGFLEN)) begin : g_lg_bad
    $error("LGFLEN out of range 1..12");
  end
  if (!af_thresh_ok(LGFLEN, AF_THRESH)) begin : g_af_bad
    $error("AF_THRESH out of range 1..depth");
  end
  if (!ae_thresh_ok(LGFLEN, AE_THRESH)) begin : g_ae_bad
    $error("AE_THRESH out of range 0..depth-1");
  end
  logic [LGFLEN:0] r_wr_addr, r_rd_addr, r_fill, w_next_fill;
  logic r_full, r_afull, r_empty, r_aempty, r_overflow, r_underflow;
  logic w_wr, w_rd;
`ifdef SFIFO_RW_ON_FULL_EN
  assign w_wr = bus.i_wr && (!r_full || bus.i_rd);
`else
  assign w_wr = bus.i_wr && !r_full;
`endif
  assign w_rd        = bus.i_rd && !r_empty;
  assign w_next_fill = r_fill + {{LGFLEN{1'b0}}, w_wr} - {{LGFLEN{1'b0}}, w_rd};
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      r_wr_addr   <= '0;
      r_rd_addr   <= '0;
      r_fill      <= '0;
      r_full      <= 1'b0;
      r_afull     <= 1'b0;
      r_empty     <= 1'b1;
      r_aempty    <= 1'b1;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_wr_addr   <= w_wr ? r_wr_addr + 1'b1 : r_wr_addr;
      r_rd_addr   <= w_rd ? r_rd_addr + 1'b1 : r_rd_addr;
      r_fill      <= w_next_fill;
      r_full      <= w_next_fill == (LGFLEN+1)'(DEPTH);
      r_afull     <= w_next_fill >= (LGFLEN+1)'(AF_THRESH);
      r_empty     <= w_next_fill == '0;
      r_aempty    <= w_next_fill <= (LGFLEN+1)'(AE_THRESH);
      r_overflow  <= !bus.i_clr_err && (r_overflow || (bus.i_wr && !w_wr));
      r_underflow <= !bus.i_clr_err && (r_underflow || (bus.i_rd && r_empty));
    end
  sfifo_mem #(.BW(BW), .LGFLEN(LGFLEN)) u_mem (
    .i_clk  (i_clk),
    .i_we   (w_wr),
    .i_waddr(r_wr_addr[LGFLEN-1:0]),
    .i_wdata(bus.i_data),
    .i_raddr(r_rd_addr[LGFLEN-1:0]),
    .o_rdata(bus.o_data)
  );
  assign bus.o_fill      = r_fill;
  assign bus.o_full      = r_full;
  assign bus.o_afull     = r_afull;
  assign bus.o_empty     = r_empty;
  assign bus.o_aempty    = r_aempty;
  assign bus.o_overflow  = r_overflow;
  assign bus.o_underflow = r_underflow;
endmodule

// File: tb/tb_sfifo_flagged.sv
// tb_sfifo_flagged: directed and random stimulus against a queue-based reference model.
module tb_sfifo_flagged;
  localparam int DEPTH = 4;
`ifdef SFIFO_RW_ON_FULL_EN
  localparam bit RWF = 1'b1;
`else
  localparam bit RWF = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  logic [7:0] q[$];
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;
  sfifo_flagged_if #(.BW(8), .LGFLEN(2)) ff();
  sfifo_flagged #(.BW(8), .LGFLEN(2), .AF_THRESH(3), .AE_THRESH(1)) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (ff)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_all();
    chk("fill", int'(ff.o_fill), q.size());
    chk("full", int'(ff.o_full), int'(q.size() == DEPTH));
    chk("empty", int'(ff.o_empty), int'(q.size() == 0));
    chk("afull", int'(ff.o_afull), int'(q.size() >= 3));
    chk("aempty", int'(ff.o_aempty), int'(q.size() <= 1));
    chk("ovf", int'(ff.o_overflow), int'(m_ovf));
    chk("unf", int'(ff.o_underflow), int'(m_unf));
    if (q.size() > 0) chk("data", int'(ff.o_data), int'(q[0]));
  endtask
  task automatic cycle(input bit wr, input logic [7:0] d, input bit rd, input bit clr);
    bit aw, ar;
    ff.i_wr = wr;
    ff.i_data = d;
    ff.i_rd = rd;
    ff.i_clr_err = clr;
    ar = rd && q.size() > 0;
    aw = wr && (q.size() < DEPTH || (RWF && rd));
    @(posedge clk);
    #1;
    if (ar) void'(q.pop_front());
    if (aw) q.push_back(d);
    if (clr) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (wr && !aw) m_ovf = 1'b1;
      if (rd && !ar) m_unf = 1'b1;
    end
    ff.i_wr = 1'b0;
    ff.i_rd = 1'b0;
    ff.i_clr_err = 1'b0;
    check_all();
  endtask
  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask
  initial begin
    ff.i_wr = 1'b0;
    ff.i_rd = 1'b0;
    ff.i_clr_err = 1'b0;
    ff.i_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_all();
    // reset in the middle of a stream holding two words
    cycle(1, 8'h11, 0, 0);
    cycle(1, 8'h22, 0, 0);
    chk("pre_rst_fill", int'(ff.o_fill), 2);
    rst = 1'b1;
    #2;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all();
    // fill stepping and threshold flags
    cycle(1, 8'hA1, 0, 0);
    cycle(1, 8'hB2, 0, 0);
    chk("aempty_at2", int'(ff.o_aempty), 0);
    cycle(1, 8'hC3, 0, 0);
    cycle(0, 8'h00, 0, 0);
    chk("afull_at3", int'(ff.o_afull), 1);
    chk("head_a1", int'(ff.o_data), 8'hA1);
    // overflow at full, then drain in order
    cycle(1, 8'hD4, 0, 0);
    cycle(1, 8'hEE, 0, 0);
    chk("ovf_set", int'(ff.o_overflow), 1);
    chk("fill_full", int'(ff.o_fill), 4);
    repeat (4) cycle(0, 8'h00, 1, 0);
    // underflow then clear
    cycle(0, 8'h00, 1, 1);
    cycle(0, 8'h00, 1, 0);
    chk("unf_set", int'(ff.o_underflow), 1);
    chk("fill_empty", int'(ff.o_fill), 0);
    cycle(0, 8'h00, 0, 1);
    chk("unf_clr", int'(ff.o_underflow), 0);
    // simultaneous read and write at full
    for (int i = 0; i < 4; i++) cycle(1, 8'(8'h60 + i), 0, 0);
    cycle(1, 8'h55, 1, 0);
    chk("rwf_fill", int'(ff.o_fill), RWF ? 4 : 3);
    chk("rwf_ovf", int'(ff.o_overflow), RWF ? 0 : 1);
    while (q.size() > 0) cycle(0, 8'h00, 1, 0);
    cycle(0, 8'h00, 0, 1);
    // steady streaming at fill 2 across pointer wrap
    cycle(1, 8'h01, 0, 0);
    cycle(1, 8'h02, 0, 0);
    for (int i = 0; i < 40; i++) cycle(1, 8'($urandom), 1, 0);
    chk("stream_fill", int'(ff.o_fill), 2);
    // unconstrained random traffic
    for (int i = 0; i < 200; i++)
      cycle(1'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 15) == 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sfifo_flagged.md
Name: sfifo_flagged

Overview:
- Parametrised successor to the basic synchronous data FIFO: single clock, power-of-two depth, first-word-fall-through read.
- Adds asynchronous reset, registered fill and status flags, and programmable almost-full/almost-empty thresholds.
- Adds sticky overflow/underflow error flags with a clear input.
- Sits between streaming producers and consumers (UART/bus bridges) where back-pressure must be signalled ahead of full.

Parameters:
- BW, 8, data width in bits.
- LGFLEN, 4, log2 of depth; depth = 2**LGFLEN; legal range 1..12.
- AF_THRESH, (1<<LGFLEN)-1, o_afull asserts when fill >= AF_THRESH; legal range 1..depth.
- AE_THRESH, 1, o_aempty asserts when fill <= AE_THRESH; legal range 0..depth-1.

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_reset  in  1  reset, asynchronous, active-high.
- i_wr  in  1  write request.
- i_data  in  BW  write data.
- o_full  out  1  registered; fill == depth.
- o_afull  out  1  registered; fill >= AF_THRESH.
- o_fill  out  LGFLEN+1  registered occupancy, 0..depth.
- i_rd  in  1  read request; pops the word currently on o_data.
- o_data  out  BW  head-of-FIFO word; valid whenever !o_empty.
- o_empty  out  1  registered; fill == 0.
- o_aempty  out  1  registered; fill <= AE_THRESH.
- o_overflow  out  1  sticky; set by a rejected write.
- o_underflow  out  1  sticky; set by a rejected read.
- i_clr_err  in  1  synchronous clear of both sticky flags.

Behaviour:
- Reset (asynchronous assert, released synchronously to i_clk by the system): wr_addr=0, rd_addr=0, o_fill=0, o_empty=1, o_full=0, o_aempty=1, o_afull=0, o_overflow=0, o_underflow=0. Memory contents are not reset.
- Pointers are LGFLEN+1 bits and wrap modulo 2**(LGFLEN+1). Memory is indexed by the low LGFLEN bits.
- Accepted write: w_wr = i_wr && (!o_full || optional case below). On an accepted write, mem[wr_addr] <= i_data and wr_addr increments.
- Accepted read: w_rd = i_rd && !o_empty. On an accepted read, rd_addr increments.
- o_data = mem[rd_addr[LGFLEN-1:0]], combinational from memory. There is no write-to-read bypass: a word written into an empty FIFO appears on o_data the cycle after the write, together with o_empty falling.
- Fill update: next_fill = o_fill + w_wr - w_rd, computed in LGFLEN+1 bits. All four level flags are registered from next_fill, so they are always consistent with o_fill in the same cycle.
- Simultaneous accepted read and write: fill and flags are unchanged; both pointers advance.
- Rejected write (i_wr && !w_wr): o_overflow <= 1; data is dropped and the pointers hold.
- Rejected read (i_rd && o_empty): o_underflow <= 1; pointers hold and o_data is don't-care.
- i_clr_err takes priority over a same-cycle set: the sticky flags read 0 on the next cycle.
- Invariant: o_fill == wr_addr - rd_addr and o_fill <= depth at all times.

Optional Feature:
- Macro: SFIFO_RW_ON_FULL_EN.
- Defined: when o_full && i_rd && i_wr, the write is accepted alongside the read. o_full stays set and o_overflow is not set.
- Undefined: a write while o_full is always rejected and sets o_overflow, even if a read happens in the same cycle.

Decomposition:
- Package sfifo_pkg holds:
  - the depth-from-LGFLEN constant function;
  - the threshold legality checks (elaboration-time errors on out-of-range AF_THRESH/AE_THRESH).
- Sub-module sfifo_mem: simple dual-port RAM with a synchronous write port and an asynchronous read port, parametrised by BW and LGFLEN.

Test Plan (BW=8, LGFLEN=2, AF_THRESH=3, AE_THRESH=1):
- Reset mid-stream with fill=2 -> next cycle o_fill=0, o_empty=1, o_aempty=1, o_full=0, error flags 0.
- Write 0xA1,0xB2,0xC3 on consecutive cycles, then idle -> o_fill steps 1,2,3; o_afull=1 after the third write; o_aempty=0 once fill reaches 2; o_data=0xA1.
- Write 4 words, then a fifth 0xEE -> o_full=1, o_overflow=1, o_fill=4; reads return the first 4 words in order, never 0xEE.
- Read while empty -> o_underflow=1, pointers unchanged; i_clr_err one cycle later -> o_underflow=0.
- At full, assert i_rd and i_wr together with 0x55 -> macro defined: o_fill stays 4, no overflow, 0x55 read out last. Macro undefined: o_fill=3, o_overflow=1.
- 40 random cycles of simultaneous read and write at fill=2, crossing pointer wrap -> o_fill stays 2 and output order matches a reference queue.
